// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and harness address map for the Wishbone initiator
//
// Contents:
//   wb_state_e   transfer sequencer states IDLE/BUS/RESP/GAP
//   ADDR_*       register windows of the multi-project harness slave bus
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } wb_state_e;

  localparam logic [31:0] ADDR_ACTIVE = 32'h3000_0000;
  localparam logic [31:0] ADDR_WS2812 = 32'h3000_0100;
  localparam logic [31:0] ADDR_7SEG   = 32'h3000_0200;
  localparam logic [31:0] ADDR_FREQ   = 32'h3000_0400;

endpackage

// File: rtl/wb_timeout_timer.sv
// rtl/wb_timeout_timer.sv - cycle counter that flags when a bus wait has run TIMEOUT cycles
//
// Ports:
//   clk_i      system clock
//   reset_i    synchronous active-high reset, count returns to 0
//   clear_i    restart the count at 0 (wins over en_i)
//   en_i       advance the count by one this cycle
//   expired_o  count has reached TIMEOUT-1, i.e. this is the last cycle allowed
module wb_timeout_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expired_o = (count_q == LAST);

  // The count parks at LAST so a stray enable can never wrap it back to 0.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_initiator.sv
// rtl/wb_initiator.sv - Wishbone classic single-transfer master with command/response handshakes
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake; cmd_we/adr/dat/sel describe the transfer
//   rsp_valid/rsp_ready             response handshake; rsp_dat read data, rsp_err timeout flag
//   wbm_cyc_o..wbm_dat_o            registered Wishbone master outputs
//   wbm_ack_i, wbm_dat_i            slave acknowledge and read data
//   err_count                       saturating count of timed-out transfers
module wb_initiator
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_adr,
  input  logic [31:0]      cmd_dat,
  input  logic [3:0]       cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_dat,
  output logic             rsp_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i,
  output logic [ERR_W-1:0] err_count
);

  wb_state_e        state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_dat_q, rsp_dat_d;
  logic             rsp_err_q, rsp_err_d;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [3:0]       sel_q, sel_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic tmr_clear;
  logic tmr_en;
  logic tmr_expired;

  wb_timeout_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk_i    (clk),
    .reset_i  (reset),
    .clear_i  (tmr_clear),
    .en_i     (tmr_en),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    err_d       = err_q;
    tmr_clear   = 1'b0;
    tmr_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // cmd_ready_q is low for the first cycle after reset, so it gates acceptance.
        if (cmd_valid && cmd_ready_q) begin
          we_d      = cmd_we;
          adr_d     = cmd_adr;
          dat_d     = cmd_dat;
          sel_d     = cmd_sel;
          cyc_d     = 1'b1;
          tmr_clear = 1'b1;
          state_d   = BUS;
        end
      end

      BUS: begin
        // ACK is checked first so an ACK on the final allowed cycle still completes.
        if (wbm_ack_i) begin
          rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          state_d     = RESP;
        end else if (tmr_expired) begin
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          if (err_q != {ERR_W{1'b1}}) begin
            err_d = err_q + 1'b1;
          end
          state_d = RESP;
        end else begin
          tmr_en = 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = GAP;
        end
      end

      GAP: begin
        // One dead cycle keeps CYC low long enough that a lingering ACK
        // from the previous transfer has cleared before the next BUS state.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'h0;
      rsp_err_q   <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= 32'h0;
      dat_q       <= 32'h0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_wb_initiator.sv
// tb/tb_wb_initiator.sv - randomized self-checking bench for wb_initiator
module tb_wb_initiator;
  import wb_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int NOACK   = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = '0;
  logic [7:0]  err_count;

  wb_initiator #(.TIMEOUT(TIMEOUT), .ERR_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Slave: acks in BUS cycle index sl_delay (counted from the first CYC-high cycle).
  int          sl_delay = NOACK;
  bit          sl_linger = 0;
  bit          sl_spur = 0;
  logic [31:0] smem [logic [31:0]];
  int          bus_cnt = 0;
  bit          linger_pend = 0;
  logic        hit;

  always @(negedge clk) begin
    if (reset) begin
      bus_cnt = 0; linger_pend = 0; wbm_ack_i = 1'b0;
    end else if (wbm_cyc_o) begin
      hit = (bus_cnt == sl_delay);
      if (hit && wbm_we_o)
        smem[wbm_adr_o] = merge(smem.exists(wbm_adr_o) ? smem[wbm_adr_o] : 32'h0,
                                wbm_dat_o, wbm_sel_o);
      wbm_ack_i = hit;
      wbm_dat_i = (hit && !wbm_we_o) ? (smem.exists(wbm_adr_o) ? smem[wbm_adr_o] : 32'h0)
                                     : $urandom;
      if (hit) linger_pend = sl_linger;
      bus_cnt++;
    end else begin
      bus_cnt = 0;
      wbm_ack_i = linger_pend | (sl_spur && ($urandom_range(0, 1) == 1));
      wbm_dat_i = $urandom;
      linger_pend = 0;
    end
  end

  // Bus monitor: CYC-high cycles, CYC rises, and field stability while CYC is high.
  logic [31:0] mon_adr, mon_dat;
  logic [3:0]  mon_sel;
  logic        mon_we;
  int          cyc_hi = 0, rises = 0, stab_err = 0;
  logic        cyc_prev = 1'b0;

  always @(negedge clk) begin
    if (wbm_cyc_o) begin
      cyc_hi++;
      if (wbm_adr_o !== mon_adr || wbm_dat_o !== mon_dat || wbm_sel_o !== mon_sel ||
          wbm_we_o !== mon_we || wbm_stb_o !== 1'b1) stab_err++;
    end
    if (wbm_cyc_o && !cyc_prev) rises++;
    cyc_prev = wbm_cyc_o;
  end

  // Reference model
  logic [31:0] ref_mem [logic [31:0]];
  int          ref_err = 0;

  // Called on a negedge; returns on a negedge.
  task automatic do_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int delay, input int hold, input string nm);
    bit          exp_to;
    int          exp_cyc, n, c0, r0, s0, bad;
    logic [31:0] exp_dat, d0;
    logic        e0;
    exp_to  = (delay >= TIMEOUT);
    exp_cyc = exp_to ? TIMEOUT : delay + 1;
    exp_dat = (we || exp_to) ? 32'h0 : (ref_mem.exists(adr) ? ref_mem[adr] : 32'h0);
    if (!exp_to && we) ref_mem[adr] = merge(ref_mem.exists(adr) ? ref_mem[adr] : 32'h0, dat, sel);
    if (exp_to && ref_err < 255) ref_err++;

    sl_delay = delay;
    mon_adr = adr; mon_dat = dat; mon_sel = sel; mon_we = we;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      chk({nm, "_accept_to"}, 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    c0 = cyc_hi; r0 = rises; s0 = stab_err;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      chk({nm, "_rsp_to"}, 0, 1);
      return;
    end
    d0 = rsp_dat; e0 = rsp_err; bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_dat !== d0 || rsp_err !== e0 || cmd_ready) bad++;
    end
    if (hold > 0) chk({nm, "_hold"}, bad, 0);
    chk({nm, "_dat"}, rsp_dat, exp_dat);
    chk({nm, "_err"}, rsp_err, exp_to);
    chk({nm, "_errcnt"}, err_count, ref_err);
    chk({nm, "_cyc_cycles"}, cyc_hi - c0, exp_cyc);
    chk({nm, "_xfers"}, rises - r0, 1);
    chk({nm, "_stable"}, stab_err - s0, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, "_rsp_drop"}, rsp_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rv;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_errcnt", err_count, 0);
    reset = 1'b0;
    @(negedge clk);

    // Write then read-back of the project-select register.
    do_xfer(1'b1, ADDR_ACTIVE, 32'h0000_0002, 4'hF, 1, 0, "wr_active");
    do_xfer(1'b0, ADDR_ACTIVE, 32'h0, 4'hF, 1, 0, "rd_active");

    // Unmapped address never acks; repeat until the counter saturates.
    do_xfer(1'b0, 32'h3000_0300, 32'h0, 4'hF, NOACK, 0, "timeout1");
    for (int i = 0; i < 299; i++) do_xfer(1'b0, 32'h3000_0300, 32'h0, 4'hF, NOACK, 0, "timeout_n");
    chk("err_saturated", err_count, 255);

    // Response back-pressure.
    do_xfer(1'b1, ADDR_FREQ, 32'hDEAD_BEEF, 4'hF, 0, 0, "wr_freq");
    do_xfer(1'b0, ADDR_FREQ, 32'h0, 4'hF, 2, 5, "rd_freq_hold");

    // Lingering ACK, second command offered during the gap.
    sl_linger = 1;
    do_xfer(1'b1, ADDR_ACTIVE, 32'h1234_5678, 4'h3, 0, 0, "linger_wr");
    do_xfer(1'b0, ADDR_FREQ, 32'h0, 4'hF, 1, 0, "linger_rd");
    sl_linger = 0;

    // Reset during BUS of a never-acked read.
    sl_delay = NOACK;
    mon_adr = ADDR_WS2812; mon_dat = 32'hA5A5_0001; mon_sel = 4'h5; mon_we = 1'b0;
    cmd_we = 1'b0; cmd_adr = ADDR_WS2812; cmd_dat = 32'hA5A5_0001; cmd_sel = 4'h5;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_cyc", wbm_cyc_o, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_cyc", wbm_cyc_o, 0);
    chk("mid_rst_stb", wbm_stb_o, 0);
    chk("mid_rst_we", wbm_we_o, 0);
    chk("mid_rst_sel", wbm_sel_o, 0);
    chk("mid_rst_adr", wbm_adr_o, 0);
    chk("mid_rst_dat", wbm_dat_o, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_dat", rsp_dat, 0);
    chk("mid_rst_rsp_err", rsp_err, 0);
    chk("mid_rst_errcnt", err_count, 0);
    reset = 1'b0;
    ref_err = 0;
    rv = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (rsp_valid || wbm_cyc_o) rv++; end
    chk("post_rst_quiet", rv, 0);
    do_xfer(1'b0, ADDR_ACTIVE, 32'h0, 4'hF, 0, 0, "post_rst_rd");

    // ACK on the final allowed cycle.
    do_xfer(1'b0, ADDR_FREQ, 32'h0, 4'hF, TIMEOUT - 1, 0, "ack_last");

    // Randomized traffic with spurious ACKs outside transfers.
    sl_spur = 1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: a = ADDR_ACTIVE;
        1: a = ADDR_WS2812;
        2: a = ADDR_7SEG;
        default: a = ADDR_FREQ;
      endcase
      a = a + 32'($urandom_range(0, 3) * 4);
      do_xfer($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 19), $urandom_range(0, 3), "rand");
    end
    sl_spur = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
